// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the digit-serial adder.
// Holds the FSM state type and the counter-width helper.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sa_state_t;

    // Counter width for n steps, never below one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Operand/result handshake bundle for serial_adder.
// Ports: in_valid/in_ready/a/b/cin in, out_valid/out_ready/sum/cout[/ovf] out.
interface serial_adder_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf;
`endif

    modport master (
        output in_valid, a, b, cin, out_ready,
`ifdef SERIAL_ADDER_OVF_EN
        input  ovf,
`endif
        input  in_ready, out_valid, sum, cout
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
`ifdef SERIAL_ADDER_OVF_EN
        output ovf,
`endif
        output in_ready, out_valid, sum, cout
    );

endinterface

// File: rtl/serial_adder_digit_adder.sv
// Combinational ripple of DIGIT full-adder cells.
// Ports: a, b, cin in; sum, cout, c_msb (carry into top bit) out.
module digit_adder #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout,
    output logic             c_msb
);
    logic [DIGIT:0] w_c;

    always_comb begin
        w_c    = '0;
        sum    = '0;
        w_c[0] = cin;
        for (int i = 0; i < DIGIT; i++) begin
            sum[i]   = a[i] ^ b[i] ^ w_c[i];
            w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout  = w_c[DIGIT];
    assign c_msb = w_c[DIGIT-1];

endmodule

// File: rtl/serial_adder.sv
// Digit-serial adder: WIDTH-bit a+b+cin, DIGIT bits per cycle.
// Ports: clk, rst (sync, active high), bus (serial_adder_if.slave). Option: SERIAL_ADDER_OVF_EN adds ovf.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input logic           clk,
    input logic           rst,
    serial_adder_if.slave bus
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = clog2_min1(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    sa_state_t        r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_cout;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [CW-1:0]    r_cnt;

    logic [DIGIT-1:0]       w_dsum;
    logic                   w_dcout;
    logic [WIDTH+DIGIT-1:0] w_cat;
    logic [WIDTH-1:0]       w_acc_next;

`ifdef SERIAL_ADDER_OVF_EN
    logic w_dmsb;
    logic r_ovf;
`else
    logic w_msb_unused;
`endif

    digit_adder #(.DIGIT(DIGIT)) u_digit (
        .a     (r_a[DIGIT-1:0]),
        .b     (r_b[DIGIT-1:0]),
        .cin   (r_carry),
        .sum   (w_dsum),
        .cout  (w_dcout),
`ifdef SERIAL_ADDER_OVF_EN
        .c_msb (w_dmsb)
`else
        .c_msb (w_msb_unused)
`endif
    );

    // New digit enters at the top; after N steps the LSB digit sits at bit 0.
    assign w_cat      = {w_dsum, r_acc};
    assign w_acc_next = w_cat[WIDTH+DIGIT-1:DIGIT];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_acc       <= '0;
            r_sum       <= '0;
            r_carry     <= 1'b0;
            r_cout      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_cnt       <= '0;
`ifdef SERIAL_ADDER_OVF_EN
            r_ovf       <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_a        <= bus.a;
                        r_b        <= bus.b;
                        r_carry    <= bus.cin;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= RUN;
                    end
                end
                RUN: begin
                    r_acc   <= w_acc_next;
                    r_a     <= r_a >> DIGIT;
                    r_b     <= r_b >> DIGIT;
                    r_carry <= w_dcout;
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        r_sum       <= w_acc_next;
                        r_cout      <= w_dcout;
`ifdef SERIAL_ADDER_OVF_EN
                        // Last digit's top cell is bit WIDTH-1.
                        r_ovf       <= w_dmsb ^ w_dcout;
`endif
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.sum       = r_sum;
    assign bus.cout      = r_cout;
`ifdef SERIAL_ADDER_OVF_EN
    assign bus.ovf       = r_ovf;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8).
// Directed tests on DIGIT=2; random traffic on DIGIT=2, 1 and 8.
module tb_serial_adder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst_r = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;
    bit   rnd_done [3];

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic.
    function automatic logic [8:0] ref_add(input logic [7:0] a,
                                           input logic [7:0] b,
                                           input logic ci);
        int s;
        s = int'(a) + int'(b) + int'(ci);
        return s[8:0];
    endfunction

    function automatic logic ref_ovf(input logic [7:0] a,
                                     input logic [7:0] b,
                                     input logic ci);
        int s;
        s = int'($signed(a)) + int'($signed(b)) + int'(ci);
        return (s > 127) || (s < -128);
    endfunction

    function automatic int dsel(input int g);
        return (g == 0) ? 2 : ((g == 1) ? 1 : 8);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed DUT ----------------
    serial_adder_if #(.WIDTH(8)) d_if ();

    serial_adder #(.WIDTH(8), .DIGIT(2)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (d_if.slave)
    );

    task automatic run_op(input string tag, input logic [7:0] a,
                          input logic [7:0] b, input logic ci,
                          input logic [7:0] es, input logic ec,
                          input logic eo);
        int lat;
        d_if.a        = a;
        d_if.b        = b;
        d_if.cin      = ci;
        d_if.in_valid = 1'b1;
        chk({tag, "_rdy"}, 32'(d_if.in_ready), 32'd1);
        step();
        d_if.in_valid = 1'b0;
        d_if.a        = 8'hxx;
        lat = 0;
        while (!d_if.out_valid && lat < 20) begin
            step();
            lat++;
        end
        chk({tag, "_lat"}, 32'(lat), 32'd4);
        chk({tag, "_sum"}, 32'(d_if.sum), 32'(es));
        chk({tag, "_cout"}, 32'(d_if.cout), 32'(ec));
`ifdef SERIAL_ADDER_OVF_EN
        chk({tag, "_ovf"}, 32'(d_if.ovf), 32'(eo));
`else
        if (eo !== 1'bx) lat = lat;
`endif
    endtask

    task automatic release_out();
        d_if.out_ready = 1'b1;
        step();
        d_if.out_ready = 1'b0;
    endtask

    // ---------------- random DUTs ----------------
    genvar g;
    generate
        for (g = 0; g < 3; g++) begin : g_rnd
            localparam int DG   = dsel(g);
            localparam int NOPS = 2000;
            serial_adder_if #(.WIDTH(8)) r_if ();
            serial_adder #(.WIDTH(8), .DIGIT(DG)) u_rnd (
                .clk (clk),
                .rst (rst_r),
                .bus (r_if.slave)
            );
            logic [9:0] q [$];

            initial begin : producer
                logic [7:0] a;
                logic [7:0] b;
                logic       ci;
                int         t;
                r_if.in_valid = 1'b0;
                r_if.a        = '0;
                r_if.b        = '0;
                r_if.cin      = 1'b0;
                wait (rst_r == 1'b0);
                step();
                for (int i = 0; i < NOPS; i++) begin
                    repeat ($urandom_range(0, 2)) step();
                    a  = 8'($urandom);
                    b  = 8'($urandom);
                    ci = 1'($urandom);
                    r_if.a        = a;
                    r_if.b        = b;
                    r_if.cin      = ci;
                    r_if.in_valid = 1'b1;
                    t = 0;
                    while (!r_if.in_ready && t < 100) begin
                        step();
                        t++;
                    end
                    if (t >= 100) begin
                        chk($sformatf("rnd%0d_accept_to", DG), 32'd0, 32'd1);
                        break;
                    end
                    q.push_back({ref_ovf(a, b, ci), ref_add(a, b, ci)});
                    step();
                    r_if.in_valid = 1'b0;
                end
            end

            initial begin : consumer
                logic [9:0] e;
                int         got;
                logic       r;
                r_if.out_ready = 1'b0;
                got = 0;
                wait (rst_r == 1'b0);
                step();
                while (got < NOPS) begin
                    r = ($urandom_range(0, 2) != 0);
                    r_if.out_ready = r;
                    if (r_if.out_valid && r) begin
                        if (q.size() == 0) begin
                            chk($sformatf("rnd%0d_extra", DG), 32'd1, 32'd0);
                        end else begin
                            e = q.pop_front();
                            chk($sformatf("rnd%0d_res", DG),
                                32'({r_if.cout, r_if.sum}), 32'(e[8:0]));
`ifdef SERIAL_ADDER_OVF_EN
                            chk($sformatf("rnd%0d_ovf", DG),
                                32'(r_if.ovf), 32'(e[9]));
`endif
                        end
                        got++;
                    end
                    step();
                end
                r_if.out_ready = 1'b0;
                rnd_done[g] = 1'b1;
            end
        end
    endgenerate

    // ---------------- main sequence ----------------
    initial begin
        logic [9:0] dq [$];
        logic [9:0] e;
        logic [7:0] a;
        logic [7:0] b;
        logic       ci;
        logic       seen;
        logic       acc;
        int         last_acc;
        int         c;

        d_if.in_valid  = 1'b0;
        d_if.out_ready = 1'b0;
        d_if.a         = '0;
        d_if.b         = '0;
        d_if.cin       = 1'b0;
        repeat (3) step();
        rst   = 1'b0;
        rst_r = 1'b0;

        chk("rst_in_ready", 32'(d_if.in_ready), 32'd1);
        chk("rst_out_valid", 32'(d_if.out_valid), 32'd0);
        chk("rst_sum", 32'(d_if.sum), 32'd0);
        chk("rst_cout", 32'(d_if.cout), 32'd0);

        run_op("t0f01", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
        release_out();
        run_op("tff01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        release_out();
        run_op("t7f00", 8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1);
        release_out();

        // Back-pressure with in_valid held high.
        run_op("bp", 8'h33, 8'h44, 1'b0, 8'h77, 1'b0, 1'b0);
        d_if.in_valid = 1'b1;
        d_if.a        = 8'h01;
        d_if.b        = 8'h02;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_valid", 32'(d_if.out_valid), 32'd1);
            chk("bp_ready", 32'(d_if.in_ready), 32'd0);
            chk("bp_sum", 32'(d_if.sum), 32'h77);
        end
        d_if.in_valid = 1'b0;
        release_out();
        chk("bp_idle_rdy", 32'(d_if.in_ready), 32'd1);
        chk("bp_idle_valid", 32'(d_if.out_valid), 32'd0);
        chk("bp_hold_sum", 32'(d_if.sum), 32'h77);

        // Reset during the second RUN cycle.
        d_if.a        = 8'h11;
        d_if.b        = 8'h22;
        d_if.cin      = 1'b0;
        d_if.in_valid = 1'b1;
        step();
        d_if.in_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mr_in_ready", 32'(d_if.in_ready), 32'd1);
        chk("mr_out_valid", 32'(d_if.out_valid), 32'd0);
        chk("mr_sum", 32'(d_if.sum), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            seen = seen | d_if.out_valid;
        end
        chk("mr_abandon", 32'(seen), 32'd0);

        // Back-to-back traffic.
        a  = 8'($urandom);
        b  = 8'($urandom);
        ci = 1'($urandom);
        d_if.a         = a;
        d_if.b         = b;
        d_if.cin       = ci;
        d_if.in_valid  = 1'b1;
        d_if.out_ready = 1'b1;
        last_acc = -1;
        for (int cyc = 0; cyc < 50; cyc++) begin
            acc = 1'b0;
            if (d_if.out_valid) begin
                if (dq.size() == 0) begin
                    chk("b2b_extra", 32'd1, 32'd0);
                end else begin
                    e = dq.pop_front();
                    chk("b2b_res", 32'({d_if.cout, d_if.sum}), 32'(e[8:0]));
                end
            end
            if (d_if.in_ready) begin
                dq.push_back({ref_ovf(a, b, ci), ref_add(a, b, ci)});
                if (last_acc >= 0) chk("b2b_gap", 32'(cyc - last_acc), 32'd6);
                last_acc = cyc;
                acc = 1'b1;
            end
            step();
            if (acc) begin
                a  = 8'($urandom);
                b  = 8'($urandom);
                ci = 1'($urandom);
                d_if.a   = a;
                d_if.b   = b;
                d_if.cin = ci;
            end
        end
        d_if.in_valid  = 1'b0;
        d_if.out_ready = 1'b0;

        c = 0;
        while (!(rnd_done[0] && rnd_done[1] && rnd_done[2]) && c < 80000) begin
            step();
            c++;
        end
        chk("rnd_complete",
            32'({rnd_done[0], rnd_done[1], rnd_done[2]}), 32'b111);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
